// File: rtl/tv80_bus_tracer.sv
// Passive Z80 bus-cycle recorder: decodes each completed tv80 bus cycle into {type, addr, data} and queues it.
// Define TV80_TRACE_RFSH_EN to also queue refresh cycles as type-6 records.
module tv80_bus_tracer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cen,
  input  logic                     m1_n,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     rfsh_n,
  input  logic [15:0]              A,
  input  logic [7:0]               di,
  input  logic [7:0]               dout,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [2:0]               rec_type,
  output logic [15:0]              rec_addr,
  output logic [7:0]               rec_data,
  output logic [$clog2(DEPTH):0]   rec_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [CNT_W-1:0]         fetch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 27;

`ifdef TV80_TRACE_RFSH_EN
  localparam bit RFSH_EN = 1'b1;
`else
  localparam bit RFSH_EN = 1'b0;
`endif

  localparam logic [2:0] T_FETCH   = 3'd0;
  localparam logic [2:0] T_MEMRD   = 3'd1;
  localparam logic [2:0] T_MEMWR   = 3'd2;
  localparam logic [2:0] T_IORD    = 3'd3;
  localparam logic [2:0] T_IOWR    = 3'd4;
  localparam logic [2:0] T_INTACK  = 3'd5;
  localparam logic [2:0] T_REFRESH = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_WAIT
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cur_type_reg, cur_type_next;
  logic [15:0]     cur_addr_reg, cur_addr_next;
  logic [7:0]      cur_data_reg, cur_data_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            overflow_reg;
  logic [CNT_W-1:0] fetch_count_reg;

  logic            strobe;
  logic [2:0]      bus_class;
  logic            start, capture, commit;
  logic            push_req, push_ok, pop, full, drop;
  logic [RW-1:0]   fifo_mem [DEPTH];
  logic [RW-1:0]   head;

  assign strobe = ~mreq_n | ~iorq_n;

  always_comb begin
    bus_class = T_IORD;
    if (~m1_n & ~iorq_n)        bus_class = T_INTACK;
    else if (~rfsh_n & ~mreq_n) bus_class = T_REFRESH;
    else if (~m1_n & ~mreq_n)   bus_class = T_FETCH;
    else if (~mreq_n & ~wr_n)   bus_class = T_MEMWR;
    else if (~mreq_n)           bus_class = T_MEMRD;
    else if (~iorq_n & ~wr_n)   bus_class = T_IOWR;
  end

  // S_WAIT holds off arming when reset releases in the middle of a bus cycle.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cen & strobe) begin
          state_next = S_ACTIVE;
          start      = 1'b1;
          capture    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cen & strobe) begin
          capture = 1'b1;
        end else if (cen) begin
          state_next = S_IDLE;
          commit     = 1'b1;
        end
      end
      S_WAIT: begin
        if (cen & ~strobe) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cur_type_next = cur_type_reg;
    cur_addr_next = cur_addr_reg;
    cur_data_next = cur_data_reg;
    if (capture) begin
      if (start) begin
        cur_type_next = bus_class;
        cur_addr_next = A;
        cur_data_next = '0;
      end
      // Refresh carries no data; interrupt acknowledge reads the vector without RD.
      if (cur_type_next == T_INTACK) begin
        if (~iorq_n) cur_data_next = di;
      end else if (cur_type_next != T_REFRESH) begin
        if (~rd_n) cur_data_next = di;
        if (~wr_n) begin
          cur_data_next = dout;
          if (cur_type_next == T_MEMRD)     cur_type_next = T_MEMWR;
          else if (cur_type_next == T_IORD) cur_type_next = T_IOWR;
        end
      end
    end
  end

  assign push_req = commit & (RFSH_EN | (cur_type_reg != T_REFRESH));
  assign full     = (count_reg == CW'(DEPTH));
  assign pop      = rec_valid & rec_ready;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {cur_type_reg, cur_addr_reg, cur_data_reg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= strobe ? S_WAIT : S_IDLE;
      cur_type_reg    <= '0;
      cur_addr_reg    <= '0;
      cur_data_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_type_reg <= cur_type_next;
      cur_addr_reg <= cur_addr_next;
      cur_data_reg <= cur_data_next;
      count_reg    <= count_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      // A drop on the same edge as a clear keeps the flag set so no loss goes unseen.
      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (push_ok && cur_type_reg == T_FETCH) fetch_count_reg <= fetch_count_reg + CNT_W'(1);
    end
  end

  assign head        = fifo_mem[rd_ptr_reg];
  assign rec_valid   = (count_reg != '0);
  assign rec_type    = rec_valid ? head[26:24] : 3'd0;
  assign rec_addr    = rec_valid ? head[23:8]  : 16'd0;
  assign rec_data    = rec_valid ? head[7:0]   : 8'd0;
  assign rec_count   = count_reg;
  assign overflow    = overflow_reg;
  assign fetch_count = fetch_count_reg;

endmodule
